// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: frame constants, FSM states
// and a small constant helper used when sizing counters.
package uart_pkg;

   localparam int UART_FRAME_BITS   = 10;
   localparam int UART_CLKS_PER_BIT = 5208;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      GAP   = 2'd3
   } sched_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational arbiter: request vector + rotating pointer -> one-hot grant and index.
// With UART_SCHED_FIXED_PRIO_EN defined the pointer is ignored and the lowest index wins.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       grant_valid
);

   localparam int IDX_W = $clog2(NUM_REQ);

`ifdef UART_SCHED_FIXED_PRIO_EN

   logic unused_ptr;
   assign unused_ptr = ^ptr;

   // Scan from the top down so the lowest set request is the last one written.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant       = '0;
            grant[i]    = 1'b1;
            grant_idx   = IDX_W'(i);
            grant_valid = 1'b1;
         end
      end
   end

`else

   logic [IDX_W-1:0] idx;

   // Walk the rotated order backwards so the request nearest the pointer wins last.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      idx         = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (req[idx]) begin
            grant       = '0;
            grant[idx]  = 1'b1;
            grant_idx   = idx;
            grant_valid = 1'b1;
         end
      end
   end

`endif

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ byte producers and self-times each frame.
// Define UART_SCHED_FIXED_PRIO_EN for fixed (lowest index first) priority instead of round-robin.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int FRAME_BITS   = UART_FRAME_BITS,
   parameter int GAP_CYCLES   = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ena,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic                       tx_start,
   output logic [7:0]                 tx_data,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       frame_done
);

   localparam int IDX_W        = $clog2(NUM_REQ);
   localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;
   localparam int CNT_W        = max_int(max_int($clog2(FRAME_CYCLES), $clog2(GAP_CYCLES + 1)), 1);

   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   sched_state_t     state;
   logic [CNT_W-1:0] cnt;
   logic [NUM_REQ-1:0] win_grant;
   logic [IDX_W-1:0] win_idx;
   logic             win_valid;
   logic [IDX_W-1:0] arb_ptr;

`ifdef UART_SCHED_FIXED_PRIO_EN

   assign arb_ptr = '0;

`else

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   logic [IDX_W-1:0] ptr;

   assign arb_ptr = ptr;

   // The pointer moves just past whoever won, so every requester gets a turn.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (state == IDLE && ena && win_valid) begin
         ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      end
   end

`endif

   rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_arbiter (
      .req        (req),
      .ptr        (arb_ptr),
      .grant      (win_grant),
      .grant_idx  (win_idx),
      .grant_valid(win_valid)
   );

   // The transmitter has no busy flag, so the frame length is counted out here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         ack        <= '0;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         grant_id   <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         ack        <= '0;
         tx_start   <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (ena && win_valid) begin
                  tx_data  <= req_data[{win_idx, 3'b000} +: 8];
                  grant_id <= win_idx;
                  ack      <= win_grant;
                  busy     <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               tx_start <= 1'b1;
               cnt      <= FRAME_LAST;
               state    <= WAIT;
            end
            WAIT: begin
               if (cnt == '0) begin
                  frame_done <= 1'b1;
                  if (GAP_CYCLES > 0) begin
                     cnt   <= GAP_LAST;
                     state <= GAP;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
